// File: rtl/fall_alarm_controller_pkg.sv
// Shared definitions for the fall alarm controller.
//   - state_t     : 2-bit FSM encoding, also driven out as stateCode
//   - CONF_CNT_W  : width of the consecutive-positive-sample counter
//   - COOL_CNT_W  : width of the cooldown down-counter
package fall_alarm_controller_pkg;

    localparam int CONF_CNT_W = 4;
    localparam int COOL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONFIRM  = 2'd1,
        ST_ALARM    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

endpackage

// File: rtl/fall_alarm_controller_if.sv
// Signal bundle between the falling detector / user controls and the
// fall alarm controller.
//   master : drives enable, sampleValid, fallDetected, ack; observes status
//   slave  : the controller; consumes the controls, drives the status outputs
//
// Handshake: sampleValid is a one-cycle strobe with no backpressure (the
// controller is always ready). fallDetected is only looked at in a cycle where
// sampleValid=1 and enable=1; ack is a level acted on in every cycle it is 1.
interface fall_alarm_controller_if #(
    parameter int EVENT_W = 8
);
    logic               enable;
    logic               sampleValid;
    logic               fallDetected;
    logic               ack;
    logic               alarm;
    logic               fallPending;
    logic               coolingDown;
    logic [EVENT_W-1:0] eventCount;
    logic [1:0]         stateCode;

    modport master (
        output enable, sampleValid, fallDetected, ack,
        input  alarm, fallPending, coolingDown, eventCount, stateCode
    );

    modport slave (
        input  enable, sampleValid, fallDetected, ack,
        output alarm, fallPending, coolingDown, eventCount, stateCode
    );
endinterface

// File: rtl/fall_alarm_controller_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clear      : synchronous clear, has priority over inc
//   inc        : add one unless already all-ones
//   count      : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/fall_alarm_controller.sv
// Fall alarm controller: confirms CONFIRM_COUNT consecutive positive samples,
// latches an alarm until ack, then ignores samples for COOLDOWN_CYCLES clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fall_alarm_controller_if
//                (inputs enable/sampleValid/fallDetected/ack,
//                 registered outputs alarm/fallPending/coolingDown/
//                 eventCount/stateCode)
module fall_alarm_controller
    import fall_alarm_controller_pkg::*;
#(
    parameter int CONFIRM_COUNT   = 4,
    parameter int COOLDOWN_CYCLES = 16,
    parameter int EVENT_W         = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fall_alarm_controller_if.slave     bus
);
    state_t                state;
    state_t                nextState;
    logic [CONF_CNT_W-1:0] confCnt;
    logic [CONF_CNT_W-1:0] confNext;
    logic [COOL_CNT_W-1:0] coolCnt;
    logic [COOL_CNT_W-1:0] coolNext;
    logic                  enterAlarm;
    logic                  alarmQ;
    logic                  pendingQ;
    logic                  coolingQ;
    logic [EVENT_W-1:0]    eventCount;

    logic validSample;
    logic posSample;
    assign validSample = bus.enable & bus.sampleValid;
    assign posSample   = validSample & bus.fallDetected;

    always_comb begin
        nextState  = state;
        confNext   = confCnt;
        coolNext   = coolCnt;
        enterAlarm = 1'b0;
        case (state)
            ST_IDLE: begin
                if (posSample) begin
                    if (CONFIRM_COUNT == 1) begin
                        nextState  = ST_ALARM;
                        confNext   = '0;
                        enterAlarm = 1'b1;
                    end else begin
                        nextState = ST_CONFIRM;
                        confNext  = CONF_CNT_W'(1);
                    end
                end
            end
            ST_CONFIRM: begin
                // Disable is checked first so it beats a simultaneous strobe.
                if (!bus.enable) begin
                    nextState = ST_IDLE;
                    confNext  = '0;
                end else if (validSample) begin
                    if (bus.fallDetected) begin
                        if ((confCnt + CONF_CNT_W'(1)) == CONF_CNT_W'(CONFIRM_COUNT)) begin
                            nextState  = ST_ALARM;
                            confNext   = '0;
                            enterAlarm = 1'b1;
                        end else begin
                            confNext = confCnt + CONF_CNT_W'(1);
                        end
                    end else begin
                        nextState = ST_IDLE;
                        confNext  = '0;
                    end
                end
            end
            ST_ALARM: begin
                if (bus.ack) begin
                    nextState = ST_COOLDOWN;
                    coolNext  = COOL_CNT_W'(COOLDOWN_CYCLES - 1);
                end
            end
            ST_COOLDOWN: begin
                // Loaded with N-1 and left when 0 is seen: N clocks in total.
                if (coolCnt == '0) begin
                    nextState = ST_IDLE;
                end else begin
                    coolNext = coolCnt - COOL_CNT_W'(1);
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            confCnt  <= '0;
            coolCnt  <= '0;
            alarmQ   <= 1'b0;
            pendingQ <= 1'b0;
            coolingQ <= 1'b0;
        end else begin
            state    <= nextState;
            confCnt  <= confNext;
            coolCnt  <= coolNext;
            alarmQ   <= (nextState == ST_ALARM);
            pendingQ <= (nextState == ST_CONFIRM);
            coolingQ <= (nextState == ST_COOLDOWN);
        end
    end

    sat_counter #(
        .W(EVENT_W)
    ) u_eventCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (enterAlarm),
        .count (eventCount)
    );

    assign bus.alarm       = alarmQ;
    assign bus.fallPending = pendingQ;
    assign bus.coolingDown = coolingQ;
    assign bus.eventCount  = eventCount;
    assign bus.stateCode   = state;
endmodule

// File: tb/tb_fall_alarm_controller.sv
// Bench for fall_alarm_controller.
//   dutA : default parameters (CONFIRM_COUNT=4, COOLDOWN_CYCLES=16, EVENT_W=8)
//   dutB : CONFIRM_COUNT=1, COOLDOWN_CYCLES=3, EVENT_W=2 (saturation corner)
module tb_fall_alarm_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fall_alarm_controller_if #(.EVENT_W(8)) ifA ();
    fall_alarm_controller_if #(.EVENT_W(2)) ifB ();

    fall_alarm_controller #(
        .CONFIRM_COUNT   (4),
        .COOLDOWN_CYCLES (16),
        .EVENT_W         (8)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    fall_alarm_controller #(
        .CONFIRM_COUNT   (1),
        .COOLDOWN_CYCLES (3),
        .EVENT_W         (2)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    typedef struct {
        logic       en;
        logic       sv;
        logic       fd;
        logic       ack;
        logic       expAlarm;
        logic       expPend;
        logic       expCool;
        logic [7:0] expCount;
        logic [1:0] expState;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] exp_q[$];

    task automatic addVec(input logic en, input logic sv, input logic fd, input logic ack,
                          input logic a, input logic p, input logic c,
                          input logic [7:0] cnt, input logic [1:0] st);
        vec_t v;
        v.en = en; v.sv = sv; v.fd = fd; v.ack = ack;
        v.expAlarm = a; v.expPend = p; v.expCool = c;
        v.expCount = cnt; v.expState = st;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic en, input logic sv, input logic fd, input logic ack);
        ifA.enable = en; ifA.sampleValid = sv; ifA.fallDetected = fd; ifA.ack = ack;
    endtask

    task automatic driveB(input logic en, input logic sv, input logic fd, input logic ack);
        ifB.enable = en; ifB.sampleValid = sv; ifB.fallDetected = fd; ifB.ack = ack;
    endtask

    task automatic checkA(input string tag, input logic a, input logic p, input logic c,
                          input logic [7:0] cnt, input logic [1:0] st);
        check({tag, ".alarm"},       32'(ifA.alarm),       32'(a));
        check({tag, ".fallPending"}, 32'(ifA.fallPending), 32'(p));
        check({tag, ".coolingDown"}, 32'(ifA.coolingDown), 32'(c));
        check({tag, ".eventCount"},  32'(ifA.eventCount),  32'(cnt));
        check({tag, ".stateCode"},   32'(ifA.stateCode),   32'(st));
    endtask

    task automatic runVecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            driveA(vecs[i].en, vecs[i].sv, vecs[i].fd, vecs[i].ack);
            step();
            checkA($sformatf("vec%0d", i), vecs[i].expAlarm, vecs[i].expPend,
                   vecs[i].expCool, vecs[i].expCount, vecs[i].expState);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Confirmed fall, strobe gap, ignored inputs in ALARM, ack.
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd0, 2'd1); // 0
        addVec(1, 0, 1, 0,  0, 1, 0, 8'd0, 2'd1); // 1 no strobe: hold
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd0, 2'd1); // 2
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd0, 2'd1); // 3
        addVec(1, 1, 1, 0,  1, 0, 0, 8'd1, 2'd2); // 4 4th positive -> ALARM
        addVec(1, 1, 1, 0,  1, 0, 0, 8'd1, 2'd2); // 5 strobes ignored
        addVec(0, 0, 0, 0,  1, 0, 0, 8'd1, 2'd2); // 6 disable ignored
        addVec(1, 1, 1, 1,  0, 0, 1, 8'd1, 2'd3); // 7 ack beats strobe
        // Broken sequence and disable handling.
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 8
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 9
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 10
        addVec(1, 1, 0, 0,  0, 0, 0, 8'd1, 2'd0); // 11 negative -> IDLE
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 12
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 13
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 14
        addVec(0, 1, 1, 0,  0, 0, 0, 8'd1, 2'd0); // 15 disable beats strobe
        addVec(0, 1, 1, 0,  0, 0, 0, 8'd1, 2'd0); // 16 IDLE disabled
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 17
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 18
        addVec(1, 1, 1, 0,  0, 1, 0, 8'd1, 2'd1); // 19
        addVec(1, 1, 1, 0,  1, 0, 0, 8'd2, 2'd2); // 20 fresh count of 4 -> ALARM

        // Clock/reset block.
        rst_n = 1'b0;
        driveA(0, 0, 0, 0);
        driveB(0, 0, 0, 0);
        repeat (3) step();
        checkA("reset", 0, 0, 0, 8'd0, 2'd0);
        check("resetB.stateCode",  32'(ifB.stateCode),  0);
        check("resetB.eventCount", 32'(ifB.eventCount), 0);
        rst_n = 1'b1;
        step();
        checkA("postReset", 0, 0, 0, 8'd0, 2'd0);

        runVecs(0, 7);

        // Cooldown: the ack edge began it; 15 more COOLDOWN cycles follow.
        for (int i = 0; i < 15; i++) begin
            if (i < 4) driveA(1, 1, 1, 1);
            else       driveA(1, 1'(i % 2), 1, 0);
            step();
            checkA($sformatf("cool%0d", i), 0, 0, 1, 8'd1, 2'd3);
        end
        driveA(1, 0, 0, 0);
        step();
        checkA("coolExit", 0, 0, 0, 8'd1, 2'd0);

        runVecs(8, 16);

        // Strobe gating: fallDetected high, no strobe.
        for (int i = 0; i < 50; i++) begin
            driveA(1, 0, 1, 0);
            step();
            check("gate.stateCode", 32'(ifA.stateCode), 0);
        end

        runVecs(17, 20);

        // Async reset mid-ALARM, between edges.
        driveA(0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        checkA("asyncReset", 0, 0, 0, 8'd0, 2'd0);
        #2;
        rst_n = 1'b1;
        step();
        checkA("afterAsync", 0, 0, 0, 8'd0, 2'd0);

        // Saturation on dutB: 5 alarm/ack/cooldown rounds.
        for (int k = 0; k < 5; k++) exp_q.push_back((k + 1 > 3) ? 2'd3 : 2'(k + 1));
        for (int k = 0; k < 5; k++) begin
            logic [1:0] expCnt;
            expCnt = exp_q.pop_front();
            driveB(1, 1, 1, 0);
            step();
            check($sformatf("sat%0d.stateCode", k), 32'(ifB.stateCode), 2);
            check($sformatf("sat%0d.eventCount", k), 32'(ifB.eventCount), 32'(expCnt));
            driveB(1, 1, 1, 1);
            step();
            check($sformatf("sat%0d.ack", k), 32'(ifB.stateCode), 3);
            driveB(1, 0, 0, 0);
            step();
            check($sformatf("sat%0d.cool1", k), 32'(ifB.stateCode), 3);
            step();
            check($sformatf("sat%0d.cool2", k), 32'(ifB.stateCode), 3);
            step();
            check($sformatf("sat%0d.idle", k), 32'(ifB.stateCode), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fall_alarm_controller.md
Name: fall_alarm_controller

Overview:
- Sequential stage directly downstream of the falling detector; consumes its combinational fallDetected flag.
- Qualifies the flag against a sample strobe and requires CONFIRM_COUNT consecutive positive samples before raising a latched alarm.
- Holds the alarm until the user acknowledges it, then enforces a cooldown window in which fall samples are ignored.
- Keeps a saturating count of confirmed fall events for display logic.

Parameters:
- CONFIRM_COUNT, 4, consecutive positive valid samples needed to confirm a fall (legal range 1..15).
- COOLDOWN_CYCLES, 16, clock cycles spent in COOLDOWN after acknowledge (legal range 1..65535).
- EVENT_W, 8, width of the confirmed-event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  arms detection; 0 disarms IDLE/CONFIRM.
- sampleValid  input  1  one-cycle strobe; fallDetected is sampled only when sampleValid=1.
- fallDetected  input  1  output of the falling detector (1 = sensor at or below the factory threshold).
- ack  input  1  user acknowledge, level or pulse; acted on in any cycle where it is 1.
- alarm  output  1  registered alarm, high only in ALARM.
- fallPending  output  1  registered, high only in CONFIRM.
- coolingDown  output  1  registered, high only in COOLDOWN.
- eventCount  output  EVENT_W  registered count of confirmed falls, saturating.
- stateCode  output  2  registered state encoding: IDLE=0, CONFIRM=1, ALARM=2, COOLDOWN=3.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state IDLE; alarm, fallPending and coolingDown all 0.
  - confirm counter 0, cooldown counter 0, eventCount 0, stateCode 0.
- Definition: a valid sample is a cycle with sampleValid=1 and enable=1. Cycles that are not valid samples never change the confirm counter.
- IDLE:
  - Valid sample with fallDetected=1: go to CONFIRM with confirm counter 1.
  - If CONFIRM_COUNT=1, go straight to ALARM instead.
- CONFIRM:
  - Valid sample with fallDetected=1: increment the confirm counter. When the incremented value equals CONFIRM_COUNT, go to ALARM.
  - Valid sample with fallDetected=0: go to IDLE and clear the counter.
  - enable=0: go to IDLE and clear the counter.
- Entry into ALARM, on the same edge as the transition:
  - eventCount increments by 1, holding at all-ones (2^EVENT_W-1) with no wrap.
  - Confirm counter clears.
- ALARM:
  - alarm=1; sample strobes and enable are ignored.
  - ack=1: go to COOLDOWN and load the cooldown counter with COOLDOWN_CYCLES-1.
- COOLDOWN:
  - Cooldown counter decrements every clock regardless of enable or samples; fallDetected is ignored.
  - When the counter is 0, return to IDLE on that edge. Total COOLDOWN residency is exactly COOLDOWN_CYCLES clocks.
  - ack has no effect.
- Latency:
  - Outputs are Moore-style, decoded from the registered state.
  - alarm rises on the edge that samples the CONFIRM_COUNT-th consecutive positive sample, so it is visible one cycle after that strobe.
  - alarm falls on the edge that samples ack.
- Simultaneous events:
  - In ALARM, ack together with a positive sample: ack wins, go to COOLDOWN.
  - In CONFIRM, enable=0 together with a positive strobe: the disable wins, go to IDLE.
  - In IDLE, enable=0 blocks all sampling.
- Reset mid-operation (any state, including ALARM with a partial cooldown): immediate return to reset values. eventCount is cleared.
- Width rules:
  - Confirm counter is 4 bits; cooldown counter is 16 bits.
  - Comparisons are unsigned. No counter wraps.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE, ST_CONFIRM, ST_ALARM, ST_COOLDOWN (2-bit).
  - Counter width constants CONF_CNT_W=4 and COOL_CNT_W=16.
- One natural sub-module: sat_counter, a parameterised-width increment-with-saturate counter with synchronous inc and clear, used for eventCount.
- Everything else (FSM, confirm counter, cooldown counter) stays in the top module.

Test Plan:
- Confirmed fall (defaults): reset, then enable=1 and 4 consecutive valid strobes with fallDetected=1 → alarm=1 one cycle after the 4th strobe, eventCount=1, stateCode=2.
- Broken sequence: 3 positive strobes, 1 strobe with fallDetected=0, then 3 positive → stays IDLE/CONFIRM, alarm never rises, eventCount=0.
- Acknowledge and cooldown: from ALARM assert ack for 1 cycle →
  - alarm=0 and coolingDown=1 for exactly 16 cycles;
  - 4 positive strobes during cooldown are ignored;
  - stateCode returns to 0 and eventCount stays 1.
- Strobe gating and disable:
  - fallDetected held at 1 with sampleValid=0 for 50 cycles → no state change.
  - enable dropped during CONFIRM → IDLE with counter cleared.
- Saturation (EVENT_W=2): 5 full confirm/ack/cooldown cycles → eventCount reads 1, 2, 3, 3, 3.
- Async reset mid-ALARM: pull rst_n low between clock edges → alarm, eventCount and stateCode read 0 immediately, before the next clock edge.
